vga_sync_gen: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 45 ++++
 rtl/vga_sync_gen_if.sv | 37 +++
 rtl/vga_sync_gen_mod_counter.sv | 38 +++
 rtl/vga_sync_gen.sv | 97 +++++++++
 tb/tb_vga_sync_gen.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 VGA timing constants, counter type and decode helpers
// shared by the sync generator, its interface and its counters.
package vga_timing_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam bit SYNC_POL_DEF = 1'b0;
  localparam int CNT_W_DEF    = 10;

  localparam int H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int H_SYNC_START = H_ACTIVE_DEF + H_FP_DEF;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF - 1;
  localparam int V_SYNC_START = V_ACTIVE_DEF + V_FP_DEF;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF - 1;

  typedef logic [CNT_W_DEF-1:0] cnt_t;

  // Registered control outputs, kept together so they update as one word.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
    logic frame_tick;
  } sync_out_t;

  function automatic logic in_range(input int val, input int lo, input int hi);
    return (val >= lo) && (val <= hi);
  endfunction

  // Drives the sync pin to the active level when asserted, else to its inverse.
  function automatic logic sync_level(input logic active, input bit pol);
    return active ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Pixel-enable input and timing outputs of the VGA sync generator; the
// generator side is master, the renderer / pin driver side is slave.
interface vga_sync_gen_if
  import vga_timing_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);

  logic             pix_en_i;
  logic             hsync_o;
  logic             vsync_o;
  logic             video_on_o;
  logic [CNT_W-1:0] pix_x_o;
  logic [CNT_W-1:0] pix_y_o;
  logic             frame_tick_o;

  modport master (
    input  pix_en_i,
    output hsync_o,
    output vsync_o,
    output video_on_o,
    output pix_x_o,
    output pix_y_o,
    output frame_tick_o
  );

  modport slave (
    output pix_en_i,
    input  hsync_o,
    input  vsync_o,
    input  video_on_o,
    input  pix_x_o,
    input  pix_y_o,
    input  frame_tick_o
  );

endinterface

// File: rtl/vga_sync_gen_mod_counter.sv
// Enabled modulo counter: counts 0..max_val, exposes its next value for
// zero-latency decode and a carry on the enabled edge that wraps it.
module mod_counter #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] max_val,
  output logic [W-1:0] cnt,
  output logic [W-1:0] cnt_nxt,
  output logic         carry
);

  assign carry = en && (cnt == max_val);

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_nxt = cnt;
    if (carry) begin
      cnt_nxt = '0;
    end else if (en) begin
      cnt_nxt = cnt + W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops sample
  // their inputs from the same edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator on the system clock, advanced by a pixel-enable strobe;
// sync, video and coordinate outputs are registered from next-state counts.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit SYNC_POL = SYNC_POL_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input logic            clk,
  input logic            rst,
  vga_sync_gen_if.master vga
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_LO = H_ACTIVE + H_FP;
  localparam int HS_HI = HS_LO + H_SYNC - 1;
  localparam int VS_LO = V_ACTIVE + V_FP;
  localparam int VS_HI = VS_LO + V_SYNC - 1;

  localparam logic [CNT_W-1:0] H_MAX = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_MAX = CNT_W'(V_TOT - 1);

  if ((H_TOT > (1 << CNT_W)) || (V_TOT > (1 << CNT_W))) begin : g_cnt_w_check
    $error("vga_sync_gen: H_TOTAL/V_TOTAL exceed 2**CNT_W");
  end

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] h_nxt;
  logic [CNT_W-1:0] v_cnt;
  logic [CNT_W-1:0] v_nxt;
  logic             h_carry;
  logic             v_carry;

  mod_counter #(.W(CNT_W)) u_h_cnt (
    .clk     (clk),
    .rst     (rst),
    .en      (vga.pix_en_i),
    .max_val (H_MAX),
    .cnt     (h_cnt),
    .cnt_nxt (h_nxt),
    .carry   (h_carry)
  );

  // The vertical counter steps only on the edge the line wraps.
  mod_counter #(.W(CNT_W)) u_v_cnt (
    .clk     (clk),
    .rst     (rst),
    .en      (h_carry),
    .max_val (V_MAX),
    .cnt     (v_cnt),
    .cnt_nxt (v_nxt),
    .carry   (v_carry)
  );

  sync_out_t out_d;
  sync_out_t out_q;

  always_comb begin
    out_d            = '0;
    out_d.hsync      = sync_level(in_range(int'(h_nxt), HS_LO, HS_HI), SYNC_POL);
    out_d.vsync      = sync_level(in_range(int'(v_nxt), VS_LO, VS_HI), SYNC_POL);
    out_d.video_on   = (int'(h_nxt) < H_ACTIVE) && (int'(v_nxt) < V_ACTIVE);
    out_d.frame_tick = v_carry;
  end

  // Outputs move only on enabled edges, so video_on stays low after reset
  // until the first pixel is actually counted; the tick is a single clk.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_q.hsync      <= ~SYNC_POL;
      out_q.vsync      <= ~SYNC_POL;
      out_q.video_on   <= 1'b0;
      out_q.frame_tick <= 1'b0;
    end else if (vga.pix_en_i) begin
      out_q <= out_d;
    end else begin
      out_q.frame_tick <= 1'b0;
    end
  end

  assign vga.hsync_o      = out_q.hsync;
  assign vga.vsync_o      = out_q.vsync;
  assign vga.video_on_o   = out_q.video_on;
  assign vga.frame_tick_o = out_q.frame_tick;
  assign vga.pix_x_o      = h_cnt;
  assign vga.pix_y_o      = v_cnt;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default 640x480 instance for line/stall/reset timing and a
// reduced-timing, active-high-sync instance for full-frame behaviour.
module tb_vga_sync_gen;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  vga_sync_gen_if #(.CNT_W(10)) m_if ();
  vga_sync_gen_if #(.CNT_W(10)) s_if ();

  vga_sync_gen dut (
    .clk (clk),
    .rst (rst),
    .vga (m_if)
  );

  // Small frame: H_TOTAL=16 (hsync 10..12), V_TOTAL=11 (vsync 7..8), 176 enables/frame.
  vga_sync_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (2),
    .SYNC_POL (1'b1), .CNT_W (10)
  ) dut_small (
    .clk (clk),
    .rst (rst),
    .vga (s_if)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic step(input logic en);
    m_if.pix_en_i = en;
    @(posedge clk);
    #1;
  endtask

  task automatic sstep(input logic en);
    s_if.pix_en_i = en;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(1'b1);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step(i[0] ? 1'b0 : 1'b1);
    total += 6;
    if (m_if.pix_x_o !== 10'd0) begin bad++; $display("FAIL reset_x got=%0d exp=0", m_if.pix_x_o); end
    if (m_if.pix_y_o !== 10'd0) begin bad++; $display("FAIL reset_y got=%0d exp=0", m_if.pix_y_o); end
    if (m_if.hsync_o !== 1'b1) begin bad++; $display("FAIL reset_hsync got=%b exp=1", m_if.hsync_o); end
    if (m_if.vsync_o !== 1'b1) begin bad++; $display("FAIL reset_vsync got=%b exp=1", m_if.vsync_o); end
    if (m_if.video_on_o !== 1'b0) begin bad++; $display("FAIL reset_video got=%b exp=0", m_if.video_on_o); end
    if (m_if.frame_tick_o !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b exp=0", m_if.frame_tick_o); end
    rst = 1'b1;
    step(1'b0);
    total += 2;
    if (m_if.video_on_o !== 1'b0) begin bad++; $display("FAIL post_reset_video got=%b exp=0", m_if.video_on_o); end
    if (m_if.pix_x_o !== 10'd0) begin bad++; $display("FAIL post_reset_x got=%0d exp=0", m_if.pix_x_o); end
  endtask

  // Alternating enable from (0,0): 800 enables end at (0,1).
  task automatic test_line();
    int lo_en, lo_clk, vid_en, first_lo, last_lo;
    lo_en = 0; lo_clk = 0; vid_en = 0; first_lo = -1; last_lo = -1;
    for (int i = 0; i < 800; i++) begin
      step(1'b1);
      if (m_if.hsync_o === 1'b0) begin
        lo_en++; lo_clk++;
        if (first_lo < 0) first_lo = int'(m_if.pix_x_o);
        last_lo = int'(m_if.pix_x_o);
      end
      if (m_if.video_on_o === 1'b1) vid_en++;
      step(1'b0);
      if (m_if.hsync_o === 1'b0) lo_clk++;
    end
    total += 7;
    if (lo_en != 96) begin bad++; $display("FAIL line_hsync_enables got=%0d exp=96", lo_en); end
    if (lo_clk != 192) begin bad++; $display("FAIL line_hsync_clks got=%0d exp=192", lo_clk); end
    if (first_lo != 656) begin bad++; $display("FAIL line_hsync_first got=%0d exp=656", first_lo); end
    if (last_lo != 751) begin bad++; $display("FAIL line_hsync_last got=%0d exp=751", last_lo); end
    if (vid_en != 640) begin bad++; $display("FAIL line_video_enables got=%0d exp=640", vid_en); end
    if (m_if.pix_x_o !== 10'd0) begin bad++; $display("FAIL line_wrap_x got=%0d exp=0", m_if.pix_x_o); end
    if (m_if.pix_y_o !== 10'd1) begin bad++; $display("FAIL line_wrap_y got=%0d exp=1", m_if.pix_y_o); end
  endtask

  task automatic test_stall();
    logic [23:0] obs;
    do_reset();
    repeat (300) step(1'b1);
    // x=300, y=0, hsync=1, vsync=1, video=1, tick=0
    for (int i = 0; i < 50; i++) begin
      step(1'b0);
      obs = {m_if.pix_x_o, m_if.pix_y_o, m_if.hsync_o, m_if.vsync_o, m_if.video_on_o, m_if.frame_tick_o};
      total++;
      if (obs !== {10'd300, 10'd0, 4'b1110}) begin
        bad++; $display("FAIL stall_hold cyc=%0d got=%h exp=%h", i, obs, {10'd300, 10'd0, 4'b1110});
      end
    end
    step(1'b1);
    total += 2;
    if (m_if.pix_x_o !== 10'd301) begin bad++; $display("FAIL stall_resume_x got=%0d exp=301", m_if.pix_x_o); end
    if (m_if.video_on_o !== 1'b1) begin bad++; $display("FAIL stall_resume_video got=%b exp=1", m_if.video_on_o); end
  endtask

  task automatic test_back_to_back();
    int lo, first_clk, vid;
    lo = 0; first_clk = -1; vid = 0;
    do_reset();
    for (int i = 1; i <= 800; i++) begin
      step(1'b1);
      if (m_if.hsync_o === 1'b0) begin
        lo++;
        if (first_clk < 0) first_clk = i;
      end
      if (m_if.video_on_o === 1'b1) vid++;
    end
    total += 5;
    if (lo != 96) begin bad++; $display("FAIL b2b_hsync_clks got=%0d exp=96", lo); end
    if (first_clk != 656) begin bad++; $display("FAIL b2b_hsync_first got=%0d exp=656", first_clk); end
    if (vid != 640) begin bad++; $display("FAIL b2b_video_clks got=%0d exp=640", vid); end
    if (m_if.pix_x_o !== 10'd0) begin bad++; $display("FAIL b2b_wrap_x got=%0d exp=0", m_if.pix_x_o); end
    if (m_if.pix_y_o !== 10'd1) begin bad++; $display("FAIL b2b_wrap_y got=%0d exp=1", m_if.pix_y_o); end
  endtask

  // Starts at (0,1) left by the back-to-back test.
  task automatic test_mid_frame_reset();
    repeat (700) step(1'b1);
    total += 3;
    if (m_if.pix_x_o !== 10'd700) begin bad++; $display("FAIL mid_pre_x got=%0d exp=700", m_if.pix_x_o); end
    if (m_if.pix_y_o !== 10'd1) begin bad++; $display("FAIL mid_pre_y got=%0d exp=1", m_if.pix_y_o); end
    if (m_if.hsync_o !== 1'b0) begin bad++; $display("FAIL mid_pre_hsync got=%b exp=0", m_if.hsync_o); end
    rst = 1'b0;
    step(1'b1);
    rst = 1'b1;
    total += 6;
    if (m_if.pix_x_o !== 10'd0) begin bad++; $display("FAIL mid_rst_x got=%0d exp=0", m_if.pix_x_o); end
    if (m_if.pix_y_o !== 10'd0) begin bad++; $display("FAIL mid_rst_y got=%0d exp=0", m_if.pix_y_o); end
    if (m_if.hsync_o !== 1'b1) begin bad++; $display("FAIL mid_rst_hsync got=%b exp=1", m_if.hsync_o); end
    if (m_if.vsync_o !== 1'b1) begin bad++; $display("FAIL mid_rst_vsync got=%b exp=1", m_if.vsync_o); end
    if (m_if.video_on_o !== 1'b0) begin bad++; $display("FAIL mid_rst_video got=%b exp=0", m_if.video_on_o); end
    if (m_if.frame_tick_o !== 1'b0) begin bad++; $display("FAIL mid_rst_tick got=%b exp=0", m_if.frame_tick_o); end
    step(1'b0);
    total++;
    if (m_if.frame_tick_o !== 1'b0) begin bad++; $display("FAIL mid_rst_tick_after got=%b exp=0", m_if.frame_tick_o); end
  endtask

  // Two full frames on the small instance, alternating enable, against a count model.
  task automatic test_frame();
    int ex, ey, ticks;
    logic et;
    logic [23:0] obs, exp_v;
    m_if.pix_en_i = 1'b0;
    rst = 1'b0;
    sstep(1'b1);
    rst = 1'b1;
    total += 2;
    if (s_if.hsync_o !== 1'b0) begin bad++; $display("FAIL frame_reset_hsync got=%b exp=0", s_if.hsync_o); end
    if (s_if.vsync_o !== 1'b0) begin bad++; $display("FAIL frame_reset_vsync got=%b exp=0", s_if.vsync_o); end
    ex = 0; ey = 0; ticks = 0;
    for (int i = 0; i < 2 * 176; i++) begin
      et = 1'b0;
      ex++;
      if (ex == 16) begin
        ex = 0;
        ey++;
        if (ey == 11) begin ey = 0; et = 1'b1; end
      end
      exp_v = {10'(ex), 10'(ey), (ex >= 10 && ex <= 12), (ey >= 7 && ey <= 8),
               (ex < 8 && ey < 6), et};
      sstep(1'b1);
      if (s_if.frame_tick_o === 1'b1) ticks++;
      obs = {s_if.pix_x_o, s_if.pix_y_o, s_if.hsync_o, s_if.vsync_o, s_if.video_on_o, s_if.frame_tick_o};
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL frame_en n=%0d got=%h exp=%h", i, obs, exp_v); end
      exp_v[0] = 1'b0;
      sstep(1'b0);
      obs = {s_if.pix_x_o, s_if.pix_y_o, s_if.hsync_o, s_if.vsync_o, s_if.video_on_o, s_if.frame_tick_o};
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL frame_hold n=%0d got=%h exp=%h", i, obs, exp_v); end
    end
    total++;
    if (ticks != 2) begin bad++; $display("FAIL frame_tick_count got=%0d exp=2", ticks); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    m_if.pix_en_i = 1'b0;
    s_if.pix_en_i = 1'b0;
    test_reset();
    test_line();
    test_stall();
    test_back_to_back();
    test_mid_frame_reset();
    test_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
